ahb_bram_ctrl: RTL and testbench
================================

# ahb_bram_ctrl

AHB-Lite slave front-end that drives the dual-address block RAM used for code/data memory in the Cortex-M0 SoC. It converts zero-wait AHB-Lite transfers into a registered byte-masked write port and a combinational read address. It also forwards write data over the RAM's read-old-data behaviour and returns a two-cycle ERROR response for illegal transfers. It sits between the AHB interconnect (decoder/mux) and the block RAM.

## Interface
- ADDR_WIDTH, 14, RAM word-address width; RAM holds 2**ADDR_WIDTH 32-bit words.
- HCLK  in  1  system clock; also clocks the RAM.
- HRESET  in  1  reset; synchronous, active-high.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  byte address; word index = HADDR[ADDR_WIDTH+1:2].
- HTRANS  in  2  transfer type; only NONSEQ (2'b10) and SEQ (2'b11) are transfers.
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word; any larger value is illegal.
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  global ready; an address phase is sampled only when HREADY=1.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data.
- BRAM_RDADDR  out  ADDR_WIDTH  RAM read address.
- BRAM_WRADDR  out  ADDR_WIDTH  RAM write address.
- BRAM_WDATA  out  32  RAM write data.
- BRAM_WRITE  out  4  RAM byte write enables.
- BRAM_RDATA  in  32  RAM registered read data; valid one cycle after BRAM_RDADDR.

## Operation
- Accept condition (acc): HSEL & HREADY & HTRANS[1].
- Byte mask:
  - size 0: one-hot at HADDR[1:0].
  - size 1: HADDR[1] ? 4'b1100 : 4'b0011.
  - size 2: 4'b1111.
- Illegal transfer, any of:
  - HSIZE > 2;
  - size 1 with HADDR[0]=1;
  - size 2 with HADDR[1:0]≠0.
- FSM states:
  - OKAY: HREADYOUT=1, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- FSM transitions:
  - OKAY→ERR1 when an illegal transfer is accepted.
  - ERR1→ERR2 unconditionally.
  - ERR2→ERR1 if another illegal transfer is accepted in ERR2; otherwise ERR2→OKAY.
- Erroneous transfers never write the RAM and never update the read-forward state.
- Write path:
  - On a legal accepted write, register word address and mask (wr_pend=1).
  - Next cycle, drive BRAM_WRADDR = registered address, BRAM_WDATA = HWDATA, BRAM_WRITE = registered mask.
  - BRAM_WRITE=0 whenever wr_pend=0.
- Read path: BRAM_RDADDR = HADDR[ADDR_WIDTH+1:2], combinational and unconditional. HRDATA comes from BRAM_RDATA in the data phase.
- Forwarding: the RAM returns old data when a read and a write hit the same word in the same cycle.
  - If a legal read is accepted while wr_pend=1 and the word addresses match, register fwd_mask = the pending write mask and fwd_data = HWDATA.
  - In the read data phase, each byte lane i of HRDATA = fwd_mask[i] ? fwd_data lane : BRAM_RDATA lane.
  - fwd_mask clears after that one cycle.
- HRDATA during write or error data phases: don't-care, but must not be X; drive BRAM_RDATA.
- Reset state: state=OKAY, wr_pend=0, fwd_mask=0.
  - Outputs at reset: HREADYOUT=1, HRESP=0, BRAM_WRITE=0.
  - A reset asserted during a write data phase suppresses that write in the same cycle.

## Timing
- Zero wait states for legal transfers: address phase at cycle N, data phase at N+1.
- Write: RAM is updated at the end of N+1.
- Read: data is on HRDATA during N+1.
- Back-to-back write (N) then read of the same word (N+1): the read data at N+2 reflects the write, bytes merged per mask.
- Read at N then write to the same word at N+1: the read returns the pre-write data.
- Error: ERR1 at N+1, ERR2 at N+2. The next address phase is sampled only at N+2.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ);
  - HSIZE codes (BYTE, HALF, WORD);
  - the response state enum (OKAY, ERR1, ERR2).
- One sub-module, ahb_lane_dec: combinational HSIZE/HADDR[1:0] → 4-bit mask plus illegal flag.

## Test plan
- Word write 0xDEADBEEF to 0x0000_0010, then idle, then word read of 0x10 → HRDATA=0xDEADBEEF; HRESP=0 throughout.
- Byte writes 0x11/0x22/0x33/0x44 to 0x20..0x23, then word read of 0x20 → 0x44332211. BRAM_WRITE sequence: 0001, 0010, 0100, 1000.
- Word 0xAAAAAAAA at 0x30, then halfword write 0x5555 at 0x32 immediately followed by a word read of 0x30 → 0x5555AAAA via forwarding.
- Word write at 0x41 → cycle N+1: HREADYOUT=0, HRESP=1; N+2: HREADYOUT=1, HRESP=1; BRAM_WRITE stays 0. A subsequent read of 0x40 returns the old contents.
- HSIZE=3 read followed directly in ERR2 by a legal word read → ERR1, ERR2, then OKAY with correct data.
- Assert HRESET during a write data phase → BRAM_WRITE=0 that cycle and the memory is unchanged. After release, HREADYOUT=1 and HRESP=0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the block-RAM slave front-end.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  // Response state: ERROR is a two-cycle response (wait, then complete).
  typedef enum logic [1:0] {
    RESP_OKAY = 2'd0,
    RESP_ERR1 = 2'd1,
    RESP_ERR2 = 2'd2
  } resp_state_e;

endpackage

// File: rtl/ahb_lane_dec.sv
// Decodes transfer size and low address bits into a byte-lane mask and
// flags unsupported sizes or misaligned transfers.
module ahb_lane_dec
  import ahb_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] mask_o,
  output logic       illegal_o
);

  // Size/alignment to lane mask; anything wider than a word is illegal.
  always_comb begin
    mask_o    = '0;
    illegal_o = 1'b0;
    case (hsize_i)
      HSIZE_BYTE: mask_o = 4'b0001 << addr_lo_i;
      HSIZE_HALF: begin
        mask_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        illegal_o = addr_lo_i[0];
      end
      HSIZE_WORD: begin
        mask_o    = 4'b1111;
        illegal_o = (addr_lo_i != 2'b00);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave front-end for a dual-address block RAM: zero-wait legal
// transfers, registered byte-masked writes, combinational read address,
// write-to-read forwarding and a two-cycle ERROR response.
module ahb_bram_ctrl
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
  output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WRITE,
  input  logic [31:0]           BRAM_RDATA
);

  logic                  acc;
  logic                  legal_acc;
  logic [3:0]            lane_mask;
  logic                  illegal;
  logic [ADDR_WIDTH-1:0] addr_word;

  resp_state_e           state_q;
  logic                  hreadyout_q;
  logic                  hresp_q;

  logic                  wr_pend_q, wr_pend_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]            wr_mask_q, wr_mask_d;
  logic [3:0]            fwd_mask_q, fwd_mask_d;
  logic [31:0]           fwd_data_q, fwd_data_d;

  logic                  unused_bits;

  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  ahb_lane_dec u_lane_dec (
    .hsize_i   (HSIZE),
    .addr_lo_i (HADDR[1:0]),
    .mask_o    (lane_mask),
    .illegal_o (illegal)
  );

  assign acc       = HSEL & HREADY & HTRANS[1];
  assign legal_acc = acc & ~illegal;
  assign addr_word = HADDR[ADDR_WIDTH+1:2];

  assign BRAM_RDADDR = addr_word;
  assign BRAM_WRADDR = wr_addr_q;
  assign BRAM_WDATA  = HWDATA;
  // Reset gates the strobe combinationally so a write in its data phase is
  // dropped in the very cycle reset is asserted.
  assign BRAM_WRITE  = (wr_pend_q & ~HRESET) ? wr_mask_q : '0;

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

  // Response FSM with registered HREADYOUT/HRESP.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= RESP_OKAY;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      case (state_q)
        RESP_ERR1: begin
          state_q     <= RESP_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        RESP_OKAY, RESP_ERR2: begin
          if (acc && illegal) begin
            state_q     <= RESP_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
          end else begin
            state_q     <= RESP_OKAY;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
        default: begin
          state_q     <= RESP_OKAY;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
        end
      endcase
    end
  end

  // Next-state for the pending write and the read-forward capture.
  always_comb begin
    wr_pend_d  = legal_acc & HWRITE;
    wr_addr_d  = wr_addr_q;
    wr_mask_d  = wr_mask_q;
    fwd_mask_d = '0;
    fwd_data_d = fwd_data_q;
    if (legal_acc && HWRITE) begin
      wr_addr_d = addr_word;
      wr_mask_d = lane_mask;
    end
    // The RAM returns old data when the pending write and this read hit the
    // same word, so the write's lanes are captured here and merged later.
    if (legal_acc && !HWRITE && wr_pend_q && (addr_word == wr_addr_q)) begin
      fwd_mask_d = wr_mask_q;
      fwd_data_d = HWDATA;
    end
  end

  // Write/forward state registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_mask_q  <= '0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      wr_pend_q  <= wr_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_mask_q  <= wr_mask_d;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // Per-lane merge of forwarded write data over the RAM read data.
  always_comb begin
    HRDATA = BRAM_RDATA;
    for (int unsigned i = 0; i < 4; i++) begin
      if (fwd_mask_q[i]) HRDATA[8*i +: 8] = fwd_data_q[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Scoreboard bench for ahb_bram_ctrl with a behavioural read-old-data RAM.
module tb_ahb_bram_ctrl;

  localparam int unsigned AW = 14;

  logic          HCLK;
  logic          HRESET;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] BRAM_RDADDR;
  logic [AW-1:0] BRAM_WRADDR;
  logic [31:0]   BRAM_WDATA;
  logic [3:0]    BRAM_WRITE;
  logic [31:0]   BRAM_RDATA;

  logic [31:0]   mem [0:(1<<AW)-1];

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned cyc;
    bit          chk_rd;
    logic [31:0] rdata;
    logic        ready;
    logic        resp;
    logic [3:0]  bw;
  } exp_t;

  exp_t q[$];

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSIZE       (HSIZE),
    .HWRITE      (HWRITE),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HREADYOUT   (HREADYOUT),
    .HRESP       (HRESP),
    .HRDATA      (HRDATA),
    .BRAM_RDADDR (BRAM_RDADDR),
    .BRAM_WRADDR (BRAM_WRADDR),
    .BRAM_WDATA  (BRAM_WDATA),
    .BRAM_WRITE  (BRAM_WRITE),
    .BRAM_RDATA  (BRAM_RDATA)
  );

  // Single slave on the bus: global ready is this slave's ready.
  assign HREADY = HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[16] = 32'h1234_5678;
    mem[20] = 32'hCAFE_F00D;
    BRAM_RDATA = '0;
  end

  // Block RAM model: registered read returning old data on collision.
  always @(posedge HCLK) begin
    BRAM_RDATA <= mem[BRAM_RDADDR];
    for (int i = 0; i < 4; i++)
      if (BRAM_WRITE[i]) mem[BRAM_WRADDR][8*i +: 8] <= BRAM_WDATA[8*i +: 8];
  end

  task automatic chk(input string name, input int unsigned c,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, got, exp);
    end
  endtask

  // Monitor: pops expectations due this cycle and compares DUT outputs.
  always @(negedge HCLK) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_expectation cyc=%0d got=none expected_cyc=%0d", cyc, e.cyc);
      end else begin
        chk("hreadyout", cyc, {31'b0, HREADYOUT}, {31'b0, e.ready});
        chk("hresp", cyc, {31'b0, HRESP}, {31'b0, e.resp});
        chk("bram_write", cyc, {28'b0, BRAM_WRITE}, {28'b0, e.bw});
        if (e.chk_rd) chk("hrdata", cyc, HRDATA, e.rdata);
      end
    end
  end

  task automatic expect_at(input int unsigned off, input bit chk_rd,
                           input logic [31:0] rd, input logic rdy,
                           input logic resp, input logic [3:0] bw);
    exp_t e;
    e.cyc = cyc + off; e.chk_rd = chk_rd; e.rdata = rd;
    e.ready = rdy; e.resp = resp; e.bw = bw;
    q.push_back(e);
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata);
    HSEL = sel; HTRANS = trans; HWRITE = wr;
    HADDR = addr; HSIZE = size; HWDATA = wdata;
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [2:0] size,
                    input logic [31:0] wdata_prev, input logic [3:0] bw);
    expect_at(1, 1'b0, '0, 1'b1, 1'b0, bw);
    drive(1'b1, 2'b10, 1'b1, addr, size, wdata_prev);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [2:0] size,
                    input logic [31:0] wdata_prev, input logic [31:0] exp);
    expect_at(1, 1'b1, exp, 1'b1, 1'b0, 4'b0000);
    drive(1'b1, 2'b10, 1'b0, addr, size, wdata_prev);
  endtask

  task automatic idle(input logic [31:0] wdata_prev);
    drive(1'b0, 2'b00, 1'b0, 32'h0, 3'd2, wdata_prev);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    HRESET = 1'b1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HADDR = '0; HSIZE = 3'd2; HWDATA = '0;
    idle(0);
    idle(0);
    expect_at(1, 1'b0, '0, 1'b1, 1'b0, 4'b0000);
    idle(0);
    HRESET = 1'b0;
    idle(0);

    // Word write, idle, read back.
    wr(32'h10, 3'd2, 32'h0, 4'b1111);
    idle(32'hDEAD_BEEF);
    rd(32'h10, 3'd2, 32'h0, 32'hDEAD_BEEF);
    idle(0);

    // Byte writes across one word.
    wr(32'h20, 3'd0, 32'h0, 4'b0001);
    wr(32'h21, 3'd0, 32'h0000_0011, 4'b0010);
    wr(32'h22, 3'd0, 32'h0000_2200, 4'b0100);
    wr(32'h23, 3'd0, 32'h0033_0000, 4'b1000);
    idle(32'h4400_0000);
    rd(32'h20, 3'd2, 32'h0, 32'h4433_2211);
    idle(0);

    // Halfword write immediately followed by word read: forwarded merge.
    wr(32'h30, 3'd2, 32'h0, 4'b1111);
    wr(32'h32, 3'd1, 32'hAAAA_AAAA, 4'b1100);
    rd(32'h30, 3'd2, 32'h5555_0000, 32'h5555_AAAA);
    idle(0);

    // Read then write of the same word: read sees pre-write data.
    rd(32'h30, 3'd2, 32'h0, 32'h5555_AAAA);
    wr(32'h30, 3'd2, 32'h0, 4'b1111);
    idle(32'h0102_0304);
    rd(32'h30, 3'd2, 32'h0, 32'h0102_0304);
    idle(0);

    // Misaligned word write: two-cycle error, no RAM write.
    expect_at(1, 1'b0, '0, 1'b0, 1'b1, 4'b0000);
    expect_at(2, 1'b0, '0, 1'b1, 1'b1, 4'b0000);
    drive(1'b1, 2'b10, 1'b1, 32'h41, 3'd2, 32'h0);
    idle(32'hFFFF_FFFF);
    rd(32'h40, 3'd2, 32'hFFFF_FFFF, 32'h1234_5678);
    idle(0);

    // HSIZE=3 read, then legal read issued in ERR2.
    expect_at(1, 1'b0, '0, 1'b0, 1'b1, 4'b0000);
    expect_at(2, 1'b0, '0, 1'b1, 1'b1, 4'b0000);
    drive(1'b1, 2'b10, 1'b0, 32'h40, 3'd3, 32'h0);
    idle(0);
    rd(32'h10, 3'd2, 32'h0, 32'hDEAD_BEEF);
    idle(0);

    // Illegal in ERR2 re-enters ERR1.
    expect_at(1, 1'b0, '0, 1'b0, 1'b1, 4'b0000);
    expect_at(2, 1'b0, '0, 1'b1, 1'b1, 4'b0000);
    drive(1'b1, 2'b11, 1'b0, 32'h11, 3'd1, 32'h0);
    idle(0);
    expect_at(1, 1'b0, '0, 1'b0, 1'b1, 4'b0000);
    expect_at(2, 1'b0, '0, 1'b1, 1'b1, 4'b0000);
    drive(1'b1, 2'b10, 1'b1, 32'h42, 3'd2, 32'h0);
    idle(0);
    expect_at(1, 1'b0, '0, 1'b1, 1'b0, 4'b0000);
    idle(0);

    // Reset during a write data phase suppresses the write.
    expect_at(1, 1'b0, '0, 1'b1, 1'b0, 4'b0000);
    drive(1'b1, 2'b10, 1'b1, 32'h50, 3'd2, 32'h0);
    HRESET = 1'b1;
    expect_at(1, 1'b0, '0, 1'b1, 1'b0, 4'b0000);
    idle(32'hBAD0_BAD0);
    HRESET = 1'b0;
    rd(32'h50, 3'd2, 32'h0, 32'hCAFE_F00D);
    idle(0);

    idle(0);
    idle(0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d expected=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
